add_sub_8bit: RTL and testbench
===============================

Name: add_sub_8bit

Overview:
- Registered two's-complement adder/subtractor. Default datapath width is 8 bits.
- A `mode` input selects the operation: 0 computes A+B, 1 computes A−B.
- Produces a sum/difference plus status flags: overflow, carry, zero, negative.
- Used as an ALU leaf in datapaths; one operation per clock, pipelined with a valid qualifier.

Parameters:
- WIDTH, 8: operand and result width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies a, b, mode this cycle.
- a  in  WIDTH  operand A (two's complement, also valid as unsigned).
- b  in  WIDTH  operand B.
- mode  in  1  0 = add (A+B), 1 = subtract (A−B).
- result  out  WIDTH  registered sum/difference, modulo 2^WIDTH.
- ovfl  out  1  registered signed-overflow flag.
- carry  out  1  registered carry-out of MSB. For subtract, 1 = no borrow.
- zero  out  1  registered: result == 0.
- neg  out  1  registered: result[WIDTH-1].
- out_valid  out  1  registered copy of in_valid.

Behaviour:
- Datapath is a ripple-carry chain of WIDTH full adders.
  - Each B bit is XORed with mode: bx = b ^ {WIDTH{mode}}.
  - Carry-in c0 = mode, so subtract is A + ~B + 1.
- Combinational sum s = a + bx + mode (WIDTH bits); cout = carry out of bit WIDTH-1.
- ovfl = carry into MSB XOR carry out of MSB. Equivalently, the operand signs agree (A vs bx) and the sign of s differs.
- zero = (s == 0); neg = s[WIDTH-1].
- Latency is 1 cycle. On a rising clk with in_valid=1, result/ovfl/carry/zero/neg load the combinational values for that cycle's a, b, mode, and out_valid←1.
- On a rising clk with in_valid=0:
  - result and flags hold their previous values.
  - out_valid←0.
- There is no backpressure. A new operation may be issued every cycle, and back-to-back inputs produce back-to-back outputs.
- rst=1 (asynchronous, at any time, including mid-stream) forces:
  - result=0, ovfl=0, carry=0, zero=1, neg=0, out_valid=0.
  - These hold while rst is asserted.
  - The first operation accepted is on the first rising clk after rst deasserts.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- Boundary cases:
  - Most-negative minus itself gives 0, zero=1, ovfl=0.
  - 0 − most-negative gives most-negative, ovfl=1.
- X/unknown on inputs while in_valid=0 must not disturb held outputs.

Test Plan:
- Reset: assert rst asynchronously mid-stream → result=0x00, zero=1, ovfl=0, carry=0, out_valid=0 immediately, without waiting for clk.
- Basic: a=0x00,b=0x01,mode=0 → result=0x01, ovfl=0, carry=0; mode=1 → result=0xFF, neg=1, carry=0 (borrow).
- Mixed signs: a=0x01,b=0xF9 → add 0xFA, ovfl=0; sub 0x08, ovfl=0, carry=0.
- Positive overflow: a=0x6D,b=0x45,mode=0 → result=0xB2, ovfl=1, neg=1, carry=0.
- Negative overflow:
  - a=0x80,b=0x9C,mode=0 → result=0x1C, ovfl=1, carry=1.
  - Same operands, mode=1 → result=0xE4, ovfl=0.
  - a=0x85,b=0x21,mode=1 → result=0x64, ovfl=1.
- Pipeline/hold:
  - Issue 0x06±0x01 and 0x15±0x31 back-to-back → results 0x07, 0x05, 0x46, 0xE4 on consecutive cycles with out_valid=1.
  - Then in_valid=0 → result holds 0xE4, out_valid=0.
  - Also check 0x01−0x01 → zero=1, carry=1.

Source files
------------

// File: rtl/add_sub_8bit.sv
// Registered two's-complement adder/subtractor with overflow, carry, zero and negative flags.
// A ripple chain of full adders forms a + (b ^ mode) + mode; one operation per clock, qualified by in_valid.
module add_sub_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             out_valid
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             sum_ovfl;
  logic             sum_carry;

  // c[i] is the carry into bit i; c[0] = mode supplies the +1 of ~b + 1 on subtract.
  always_comb begin
    bx   = b ^ {WIDTH{mode}};
    sum  = '0;
    c    = '0;
    c[0] = mode;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end
    sum_carry = c[WIDTH];
    sum_ovfl  = c[WIDTH-1] ^ c[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      ovfl      <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= sum;
        ovfl   <= sum_ovfl;
        carry  <= sum_carry;
        zero   <= (sum == '0);
        neg    <= sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_add_sub_8bit.sv
// Self-checking bench for add_sub_8bit: directed cases, random stream, hold and async reset,
// compared against an integer-arithmetic reference model.
module tb_add_sub_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         mode;
  logic [W-1:0] result;
  logic         ovfl, carry, zero, neg, out_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] e_result;
  logic         e_ovfl, e_carry, e_zero, e_neg, e_valid;

  add_sub_8bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .result(result), .ovfl(ovfl), .carry(carry), .zero(zero), .neg(neg),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic, no carry chain.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mm, output logic [W-1:0] r,
                                output logic o, output logic c, output logic z,
                                output logic n);
    int sa, sb, sr, ua, ub;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = ma;
    ub = mb;
    sr = mm ? (sa - sb) : (sa + sb);
    r  = mm ? W'(ua - ub) : W'(ua + ub);
    c  = mm ? (ua >= ub) : ((ua + ub) >= (1 << W));
    o  = (sr > (2**(W-1) - 1)) || (sr < -(2**(W-1)));
    z  = (r == '0);
    n  = r[W-1];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".result"},    result,               e_result);
    chk({tag, ".ovfl"},      {{(W-1){1'b0}}, ovfl},      {{(W-1){1'b0}}, e_ovfl});
    chk({tag, ".carry"},     {{(W-1){1'b0}}, carry},     {{(W-1){1'b0}}, e_carry});
    chk({tag, ".zero"},      {{(W-1){1'b0}}, zero},      {{(W-1){1'b0}}, e_zero});
    chk({tag, ".neg"},       {{(W-1){1'b0}}, neg},       {{(W-1){1'b0}}, e_neg});
    chk({tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, e_valid});
  endtask

  task automatic set_reset_exp();
    e_result = '0; e_ovfl = 0; e_carry = 0; e_zero = 1; e_neg = 0; e_valid = 0;
  endtask

  // Drive one cycle at the falling edge, check #1 after the rising edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] sa,
                      input logic [W-1:0] sb, input logic sm);
    @(negedge clk);
    in_valid = v;
    if (v) begin
      a = sa; b = sb; mode = sm;
      model(sa, sb, sm, e_result, e_ovfl, e_carry, e_zero, e_neg);
    end else begin
      a = 'x; b = 'x; mode = 1'bx;
    end
    e_valid = v;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
    set_reset_exp();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("basic_add",    1, 8'h00, 8'h01, 0);
    if (result !== 8'h01) $display("note: basic add result %h", result);
    step("basic_sub",    1, 8'h00, 8'h01, 1);
    step("mixed_add",    1, 8'h01, 8'hF9, 0);
    step("mixed_sub",    1, 8'h01, 8'hF9, 1);
    step("pos_ovfl",     1, 8'h6D, 8'h45, 0);
    step("neg_ovfl_add", 1, 8'h80, 8'h9C, 0);
    step("neg_sub",      1, 8'h80, 8'h9C, 1);
    step("neg_ovfl_sub", 1, 8'h85, 8'h21, 1);
    step("minneg_self",  1, 8'h80, 8'h80, 1);
    step("zero_minneg",  1, 8'h00, 8'h80, 1);
    step("one_minus_one",1, 8'h01, 8'h01, 1);
    step("max_plus_one", 1, 8'h7F, 8'h01, 0);
    step("ff_plus_one",  1, 8'hFF, 8'h01, 0);

    // Directed constants independent of the model for key test-plan points.
    chk("const_ff_plus_one", result, 8'h00);
    chk("const_ff_carry", {7'b0, carry}, 8'h01);

    step("pipe0", 1, 8'h06, 8'h01, 0);
    chk("const_pipe0", result, 8'h07);
    step("pipe1", 1, 8'h06, 8'h01, 1);
    chk("const_pipe1", result, 8'h05);
    step("pipe2", 1, 8'h15, 8'h31, 0);
    chk("const_pipe2", result, 8'h46);
    step("pipe3", 1, 8'h15, 8'h31, 1);
    chk("const_pipe3", result, 8'hE4);
    step("hold0", 0, 8'h00, 8'h00, 0);
    chk("const_hold", result, 8'hE4);
    step("hold1", 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rand%0d", i), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-stream, asserted away from any clock edge.
    step("pre_rst", 1, 8'h6D, 8'h45, 0);
    @(negedge clk);
    in_valid = 1'b1; a = 8'h12; b = 8'h34; mode = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    set_reset_exp();
    chk_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, 8'h12, 8'h34, 1);
    step("post_rst_idle", 0, 8'h00, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
